// File: rtl/amp_i2c_monitor.sv
// amp_i2c_monitor: passive START..STOP decoder for the amplifier I2C bus.
// Optional idle-SCL watchdog is built when AMP_I2C_MON_TIMEOUT_EN is defined.
module amp_i2c_monitor #(
   parameter logic [6:0]  ADDR7       = 7'b0100000,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic       clk_in,
   input  logic       resetb,
   input  logic       scl,
   input  logic       sdao,
   input  logic       sdai,
   input  logic       clr_status,
   output logic       busy,
   output logic       frame_done,
   output logic       nack_err,
   output logic       addr_err,
   output logic       frame_err,
   output logic       timeout_err,
   output logic [7:0] xfer_cnt,
   output logic [7:0] last_byte
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_BYTE, S_ACK} state_t;

   localparam logic [7:0] ADDR_BYTE = {ADDR7, 1'b0};

   state_t     state;
   logic       sda_b;
   logic [1:0] scl_sync, sda_sync;
   logic       scl_d, sda_d;
   logic       scl_s, sda_s;
   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [2:0] bit_cnt;
   logic       bit_pend;
   logic [3:0] byte_idx;
   logic [7:0] shreg;

   assign sda_b = sdao & sdai;

   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda_b};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

`ifdef AMP_I2C_MON_TIMEOUT_EN
   localparam logic [9:0] WD_LIM = 10'(TIMEOUT_CYC);

   logic [9:0] wd_cnt;
   logic       wd_hit;

   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb)
         wd_cnt <= '0;
      else if (!busy || scl_rise || scl_fall)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 10'd1;
   end

   assign wd_hit = busy && (wd_cnt == WD_LIM);
`else
   assign timeout_err = 1'b0 & (TIMEOUT_CYC == 32'd0);
`endif

   always_ff @(posedge clk_in or negedge resetb) begin
      if (!resetb) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         nack_err   <= 1'b0;
         addr_err   <= 1'b0;
         frame_err  <= 1'b0;
         xfer_cnt   <= '0;
         last_byte  <= '0;
         bit_cnt    <= '0;
         bit_pend   <= 1'b0;
         byte_idx   <= '0;
         shreg      <= '0;
`ifdef AMP_I2C_MON_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         // Clear first so a flag set later in this block takes priority.
         if (clr_status) begin
            nack_err  <= 1'b0;
            addr_err  <= 1'b0;
            frame_err <= 1'b0;
            xfer_cnt  <= '0;
`ifdef AMP_I2C_MON_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
         end
         if (state != S_IDLE && stop_det) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            if (bit_cnt != '0)
               frame_err <= 1'b1;
            if (!clr_status && xfer_cnt != 8'hFF)
               xfer_cnt <= xfer_cnt + 8'd1;
         end
`ifdef AMP_I2C_MON_TIMEOUT_EN
         else if (wd_hit) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
         end
`endif
         else begin
            case (state)
               S_IDLE: begin
                  if (start_det) begin
                     state    <= S_START;
                     busy     <= 1'b1;
                     bit_cnt  <= '0;
                     bit_pend <= 1'b0;
                     byte_idx <= '0;
                  end
               end
               S_START: state <= S_BYTE;
               S_BYTE, S_ACK: begin
                  if (start_det) begin
                     if (bit_cnt != '0)
                        frame_err <= 1'b1;
                     bit_cnt  <= '0;
                     bit_pend <= 1'b0;
                     byte_idx <= '0;
                     state    <= S_START;
                  end else if (state == S_BYTE) begin
                     // Bits are sampled on the rise but only counted on the
                     // following fall, so the SCL rise that precedes a STOP or
                     // repeated START does not look like a stray data bit.
                     if (scl_rise) begin
                        shreg    <= {shreg[6:0], sda_s};
                        bit_pend <= 1'b1;
                     end else if (scl_fall && bit_pend) begin
                        bit_pend <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                           bit_cnt <= '0;
                           state   <= S_ACK;
                        end else begin
                           bit_cnt <= bit_cnt + 3'd1;
                        end
                     end
                  end else if (scl_rise) begin
                     if (sda_s)
                        nack_err <= 1'b1;
                     if (byte_idx == '0 && shreg != ADDR_BYTE)
                        addr_err <= 1'b1;
                     last_byte <= shreg;
                     if (byte_idx != 4'hF)
                        byte_idx <= byte_idx + 4'd1;
                     state <= S_BYTE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_amp_i2c_monitor.sv
// Directed bench for amp_i2c_monitor: master-style frames drive a scoreboard of
// expected per-frame status that is checked on each frame_done pulse.
`timescale 1ns/1ps
module tb_amp_i2c_monitor;

   localparam int P = 5;

   logic       clk_in = 1'b0;
   logic       resetb, scl, sdao, sdai, clr_status;
   logic       busy, frame_done, nack_err, addr_err, frame_err, timeout_err;
   logic [7:0] xfer_cnt, last_byte;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic       fe;
      logic       ae;
      logic       ne;
      logic [7:0] cnt;
      logic [7:0] lb;
   } exp_t;

   exp_t sb_q[$];

   logic       m_ne, m_ae, m_fe, m_partial;
   logic [7:0] m_cnt, m_lb;
   int         m_idx;

   amp_i2c_monitor #(
      .ADDR7       (7'b0100000),
      .TIMEOUT_CYC (20)
   ) dut (
      .clk_in      (clk_in),
      .resetb      (resetb),
      .scl         (scl),
      .sdao        (sdao),
      .sdai        (sdai),
      .clr_status  (clr_status),
      .busy        (busy),
      .frame_done  (frame_done),
      .nack_err    (nack_err),
      .addr_err    (addr_err),
      .frame_err   (frame_err),
      .timeout_err (timeout_err),
      .xfer_cnt    (xfer_cnt),
      .last_byte   (last_byte)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic model_clear();
      m_ne  = 1'b0;
      m_ae  = 1'b0;
      m_fe  = 1'b0;
      m_cnt = 8'd0;
   endtask

   task automatic i2c_start();
      int lat = 0;
      sdao = 1'b1; sdai = 1'b1; scl = 1'b1;
      cyc(P);
      sdao = 1'b0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk_in);
         if (busy) lat = i;
      end
      chk("busy_rise_latency", 32'(lat), 32'd3);
      cyc(P);
      scl = 1'b0;
      cyc(P);
      m_idx = 0;
      m_partial = 1'b0;
   endtask

   task automatic i2c_bit(input logic b, input logic a);
      sdao = b; sdai = a;
      cyc(P);
      scl = 1'b1;
      cyc(P);
      scl = 1'b0;
      cyc(P);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ackv);
      for (int i = 7; i >= 0; i--) i2c_bit(d[i], 1'b1);
      i2c_bit(1'b1, ackv);
      if (ackv) m_ne = 1'b1;
      if (m_idx == 0 && d != 8'h40) m_ae = 1'b1;
      m_lb = d;
      m_idx++;
      m_partial = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) i2c_bit(d[7-i], 1'b1);
      m_partial = (n != 0);
   endtask

   task automatic rep_start();
      sdao = 1'b1; sdai = 1'b1;
      cyc(P);
      scl = 1'b1;
      cyc(P);
      sdao = 1'b0;
      cyc(P);
      chk("busy_hold_rstart", 32'(busy), 32'd1);
      scl = 1'b0;
      cyc(P);
      if (m_partial) m_fe = 1'b1;
      m_partial = 1'b0;
      m_idx = 0;
   endtask

   task automatic i2c_stop(input bit clr_done);
      exp_t e;
      int   lat = 0;
      sdao = 1'b0; sdai = 1'b1;
      cyc(P);
      scl = 1'b1;
      cyc(P);
      if (m_partial) m_fe = 1'b1;
      if (clr_done) begin
         m_ne  = 1'b0;
         m_ae  = 1'b0;
         m_cnt = 8'd0;
         m_fe  = m_partial;
      end else if (m_cnt != 8'hFF) begin
         m_cnt++;
      end
      m_partial = 1'b0;
      e.fe = m_fe; e.ae = m_ae; e.ne = m_ne; e.cnt = m_cnt; e.lb = m_lb;
      sb_q.push_back(e);
      sdao = 1'b1;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         if (clr_done && i == 3) clr_status = 1'b1;
         @(negedge clk_in);
         clr_status = 1'b0;
         if (frame_done) lat = i;
      end
      chk("frame_done_latency", 32'(lat), 32'd3);
      if (lat != 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("frame_err", 32'(frame_err), 32'(e.fe));
         chk("addr_err", 32'(addr_err), 32'(e.ae));
         chk("nack_err", 32'(nack_err), 32'(e.ne));
         chk("xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
         chk("last_byte", 32'(last_byte), 32'(e.lb));
         chk("busy_fall", 32'(busy), 32'd0);
         @(negedge clk_in);
         chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
      end
      cyc(P);
   endtask

   task automatic clr_pulse();
      clr_status = 1'b1;
      @(negedge clk_in);
      clr_status = 1'b0;
      model_clear();
      chk("clr_nack", 32'(nack_err), 32'd0);
      chk("clr_addr", 32'(addr_err), 32'd0);
      chk("clr_frame", 32'(frame_err), 32'd0);
      chk("clr_timeout", 32'(timeout_err), 32'd0);
      chk("clr_xfer_cnt", 32'(xfer_cnt), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_nack"}, 32'(nack_err), 32'd0);
      chk({tag, "_addr"}, 32'(addr_err), 32'd0);
      chk({tag, "_frame"}, 32'(frame_err), 32'd0);
      chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
      chk({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'd0);
      chk({tag, "_last_byte"}, 32'(last_byte), 32'd0);
   endtask

   initial begin
      bit seen;
      int t;
      resetb = 1'b0; scl = 1'b1; sdao = 1'b1; sdai = 1'b1; clr_status = 1'b0;
      model_clear();
      m_lb = 8'h00; m_partial = 1'b0; m_idx = 0;
      cyc(3);
      chk_reset_vals("reset");
      resetb = 1'b1;
      cyc(P);

      // Fully ACKed write: addr 0x40, reg 0x18, data 0x08
      i2c_start(); send_byte(8'h40, 1'b0); send_byte(8'h18, 1'b0); send_byte(8'h08, 1'b0);
      i2c_stop(1'b0);
      clr_pulse();

      // NACK in the data slot
      i2c_start(); send_byte(8'h40, 1'b0); send_byte(8'h18, 1'b0); send_byte(8'h08, 1'b1);
      i2c_stop(1'b0);
      clr_pulse();

      // Wrong address, data still decoded
      i2c_start(); send_byte(8'h42, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h5A, 1'b0);
      i2c_stop(1'b0);
      clr_pulse();

      // STOP after 4 bits of the second byte
      i2c_start(); send_byte(8'h40, 1'b0); send_bits(8'h18, 4);
      i2c_stop(1'b0);
      clr_pulse();

      // Repeated START mid-byte, then a full frame; counted once
      i2c_start(); send_byte(8'h40, 1'b0); send_bits(8'h18, 3);
      rep_start(); send_byte(8'h40, 1'b0); send_byte(8'h33, 1'b0);
      i2c_stop(1'b0);
      clr_pulse();

      // Five good frames, then clr_status coincident with the sixth frame_done
      for (int k = 0; k < 5; k++) begin
         i2c_start(); send_byte(8'h40, 1'b0); send_byte(8'(k + 1), 1'b0);
         i2c_stop(1'b0);
      end
      i2c_start(); send_byte(8'h40, 1'b1); send_bits(8'hF0, 4);
      i2c_stop(1'b1);
      clr_pulse();

      // STOP pattern while idle is ignored
      seen = 1'b0;
      scl = 1'b0; cyc(P);
      sdao = 1'b0; cyc(P);
      scl = 1'b1; cyc(P);
      sdao = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         if (frame_done) seen = 1'b1;
      end
      chk("idle_stop_no_done", 32'(seen), 32'd0);
      chk("idle_stop_busy", 32'(busy), 32'd0);
      chk("idle_stop_frame_err", 32'(frame_err), 32'd0);
      chk("idle_stop_xfer_cnt", 32'(xfer_cnt), 32'd0);

`ifdef AMP_I2C_MON_TIMEOUT_EN
      // Freeze SCL low mid-byte
      i2c_start(); send_bits(8'hA0, 3);
      seen = 1'b0;
      t = 0;
      for (int i = 1; i <= 60 && t == 0; i++) begin
         @(negedge clk_in);
         if (frame_done) seen = 1'b1;
         if (!busy) t = i;
      end
      chk("timeout_fired", 32'(t != 0), 32'd1);
      chk("timeout_not_early", 32'(t > 10), 32'd1);
      chk("timeout_err", 32'(timeout_err), 32'd1);
      chk("timeout_no_done", 32'(seen), 32'd0);
      chk("timeout_xfer_cnt", 32'(xfer_cnt), 32'd0);
      sdao = 1'b1; sdai = 1'b1;
      cyc(P);
      scl = 1'b1;
      cyc(P);
      m_partial = 1'b0;
      clr_pulse();
`else
      chk("timeout_tied_low", 32'(timeout_err), 32'd0);
`endif

      // Async reset mid-frame, then decoding restarts cleanly
      i2c_start(); send_byte(8'h42, 1'b0); send_bits(8'h55, 5);
      chk("pre_reset_addr_err", 32'(addr_err), 32'd1);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      #2 resetb = 1'b0;
      #1;
      chk_reset_vals("midframe_reset");
      scl = 1'b1; sdao = 1'b1; sdai = 1'b1;
      cyc(2);
      resetb = 1'b1;
      model_clear();
      m_lb = 8'h00; m_partial = 1'b0; m_idx = 0;
      cyc(P);
      i2c_start(); send_byte(8'h40, 1'b0); send_byte(8'h18, 1'b0); send_byte(8'h08, 1'b0);
      i2c_stop(1'b0);

      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/amp_i2c_monitor.md
# amp_i2c_monitor

Passive I2C bus monitor sitting directly downstream of the amplifier I2C master. It consumes the master's `scl`/`sdao` and the amplifier's returned `sdai` and decodes each START…STOP frame bit by bit. It checks the device address and every ACK slot, and reports per-frame completion, sticky error flags and a frame counter. Firmware and the top-level status register read this to confirm that the amplifier boot configuration was accepted.

## Interface
Parameters:
- `ADDR7`, default 7'b0100000: expected 7-bit amplifier device address.
- `TIMEOUT_CYC`, default 1023: idle-`scl` watchdog limit in `clk_in` cycles. Used only with `AMP_I2C_MON_TIMEOUT_EN`.

Ports:
- `clk_in`  input  1  system clock; the master's divided clock is derived from it.
- `resetb`  input  1  reset, asynchronous, active-low.
- `scl`  input  1  master SCL.
- `sdao`  input  1  master SDA drive (1 = released).
- `sdai`  input  1  SDA returned from the amplifier (0 = pulled low).
- `clr_status`  input  1  synchronous clear of sticky flags and counter.
- `busy`  output  1  high from START detect to STOP detect.
- `frame_done`  output  1  one-cycle pulse on STOP detect.
- `nack_err`  output  1  sticky: an ACK slot read 1.
- `addr_err`  output  1  sticky: address byte ≠ {ADDR7, 1'b0}.
- `frame_err`  output  1  sticky: STOP or repeated START seen with bit count ≠ 0.
- `timeout_err`  output  1  sticky watchdog flag; tied 0 when the macro is absent.
- `xfer_cnt`  output  8  count of completed frames, saturating at 255.
- `last_byte`  output  8  last fully received byte.

## Operation
- The bus SDA is `sda_b = sdao & sdai` (wired-AND). `scl` and `sda_b` each pass through a 2-flop synchronizer. All edge detection uses the synchronized values and their 1-cycle-delayed copies.
- START: `sda_b` falls while `scl` is high. STOP: `sda_b` rises while `scl` is high. Data bits and ACK bits are sampled on `scl` rising edges only.
- FSM states:
  - IDLE → START → BYTE.
  - BYTE: shift 8 bits MSB first, `bit_cnt` 0..7 → ACK.
  - ACK: sample the 9th bit. If 1, set `nack_err`. If `byte_idx`==0 and the byte ≠ {ADDR7,0}, set `addr_err`. Load `last_byte`, increment `byte_idx` (4-bit, saturating), → BYTE.
  - STOP from any non-IDLE state → IDLE. Pulse `frame_done`, increment `xfer_cnt`.
- Repeated START in BYTE or ACK: reset `bit_cnt` and `byte_idx` to 0 and stay busy. Set `frame_err` if `bit_cnt` ≠ 0. `xfer_cnt` does not increment.
- STOP with `bit_cnt` ≠ 0 (mid-byte): set `frame_err`. Still count the frame and pulse `frame_done`.
- STOP or SCL activity while in IDLE is ignored; no error is raised.
- `clr_status`:
  - Clears all sticky flags and `xfer_cnt`.
  - On a flag set coinciding with `clr_status`, the set wins.
  - On `frame_done` coinciding with `clr_status`, `xfer_cnt` becomes 0 (clear wins).
- Async reset mid-frame returns to IDLE immediately. Frame decoding restarts at the next START.

## Timing
- Reset values: `busy`=0, `frame_done`=0, all error flags=0, `xfer_cnt`=0, `last_byte`=8'h00, FSM=IDLE. Synchronizers reset to 1.
- Input-to-detect latency is 3 `clk_in` cycles (2 synchronizer stages + 1 edge register).
  - `busy` rises 3 cycles after the raw START edge.
  - `frame_done` pulses, and `busy` falls, 3 cycles after the raw STOP edge.
- Error flags and `last_byte` update on the cycle after the synchronized 9th `scl` rise.
- `xfer_cnt` updates in the same cycle as `frame_done`.
- Minimum input pulse width is 2 `clk_in` cycles. The master's divide-by-5 clock gives ≥5.

## Configuration
- `AMP_I2C_MON_TIMEOUT_EN` defined:
  - An 10-bit counter increments while `busy` and resets on every synchronized `scl` edge.
  - On reaching `TIMEOUT_CYC`: set `timeout_err`, return to IDLE, `busy`=0. No `frame_done` pulse and no `xfer_cnt` increment.
- Undefined: no counter is built and `timeout_err` is constant 0. A stalled bus leaves `busy` high until a STOP or reset.

## Test plan
- Master-style write, addr 0x40, reg 0x18, data 0x08, all ACKed (`sdai` low in ACK slots) -> `frame_done` pulse, `xfer_cnt`=1, `last_byte`=0x08, no flags set.
- Same frame with `sdai` held 1 in the data ACK slot -> `nack_err`=1, `addr_err`=0, `xfer_cnt`=1.
- Address byte 0x42 -> `addr_err`=1; data is still decoded and `last_byte` = final byte.
- STOP after 4 bits of the second byte -> `frame_err`=1, `frame_done` pulses, `xfer_cnt` increments.
- Assert `clr_status` in the same cycle as `frame_done` with `xfer_cnt`=5 -> `xfer_cnt`=0; flags cleared unless set in that cycle.
- With `AMP_I2C_MON_TIMEOUT_EN`, `TIMEOUT_CYC`=20, freeze `scl` mid-byte -> `timeout_err`=1 after 20 cycles, `busy`=0, `xfer_cnt` unchanged. Reset asserted mid-frame -> all outputs return to reset values immediately.
